// File: rtl/udma_qspi_cmd_seq_pkg.sv
// SPIM command-word opcodes, sequencer state encoding and command-word packers
// shared between the QSPI read sequencer and the SPIM core.
package udma_qspi_cmd_seq_pkg;

  localparam int unsigned SPIM_WORD_W = 32;

  localparam logic [3:0] SPIM_CMD_CFG       = 4'd0;
  localparam logic [3:0] SPIM_CMD_SOT       = 4'd1;
  localparam logic [3:0] SPIM_CMD_SEND_CMD  = 4'd2;
  localparam logic [3:0] SPIM_CMD_SEND_ADDR = 4'd3;
  localparam logic [3:0] SPIM_CMD_DUMMY     = 4'd4;
  localparam logic [3:0] SPIM_CMD_RX_DATA   = 4'd7;
  localparam logic [3:0] SPIM_CMD_EOT       = 4'd9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG,
    ST_SOT,
    ST_CMD,
    ST_ADDR_HDR,
    ST_ADDR_DAT,
    ST_DUMMY,
    ST_RX,
    ST_EOT
  } cmd_seq_state_e;

  // Request fields captured on accept and held for the whole transfer
  typedef struct packed {
    logic [7:0] clkdiv;
    logic [1:0] mode;
    logic [7:0] opcode;
    logic       addr4b;
    logic [4:0] dummy;
    logic       qpi;
    logic [1:0] cs;
  } seq_req_t;

  function automatic logic [SPIM_WORD_W-1:0] spim_cfg_word(input logic [7:0] clkdiv,
                                                           input logic [1:0] mode);
    logic [SPIM_WORD_W-1:0] w;
    w        = '0;
    w[31:28] = SPIM_CMD_CFG;
    w[9:8]   = mode;
    w[7:0]   = clkdiv;
    return w;
  endfunction

  function automatic logic [SPIM_WORD_W-1:0] spim_sot_word(input logic [1:0] cs);
    logic [SPIM_WORD_W-1:0] w;
    w        = '0;
    w[31:28] = SPIM_CMD_SOT;
    w[1:0]   = cs;
    return w;
  endfunction

  function automatic logic [SPIM_WORD_W-1:0] spim_send_cmd_word(input logic       qpi,
                                                                input logic [7:0] opcode);
    logic [SPIM_WORD_W-1:0] w;
    w        = '0;
    w[31:28] = SPIM_CMD_SEND_CMD;
    w[27]    = qpi;
    w[19:16] = 4'd7;
    w[7:0]   = opcode;
    return w;
  endfunction

  function automatic logic [SPIM_WORD_W-1:0] spim_send_addr_word(input logic qpi,
                                                                 input logic addr4b);
    logic [SPIM_WORD_W-1:0] w;
    w        = '0;
    w[31:28] = SPIM_CMD_SEND_ADDR;
    w[27]    = qpi;
    w[20:16] = addr4b ? 5'd31 : 5'd23;
    return w;
  endfunction

  function automatic logic [SPIM_WORD_W-1:0] spim_dummy_word(input logic [4:0] dummy);
    logic [SPIM_WORD_W-1:0] w;
    w        = '0;
    w[31:28] = SPIM_CMD_DUMMY;
    w[20:16] = dummy - 5'd1;
    return w;
  endfunction

  function automatic logic [SPIM_WORD_W-1:0] spim_rx_word(input logic        qpi,
                                                          input logic [15:0] len_m1);
    logic [SPIM_WORD_W-1:0] w;
    w        = '0;
    w[31:28] = SPIM_CMD_RX_DATA;
    w[27]    = qpi;
    w[15:0]  = len_m1;
    return w;
  endfunction

  function automatic logic [SPIM_WORD_W-1:0] spim_eot_word(input logic evt);
    logic [SPIM_WORD_W-1:0] w;
    w        = '0;
    w[31:28] = SPIM_CMD_EOT;
    w[0]     = evt;
    return w;
  endfunction

endpackage

// File: rtl/udma_qspi_cmd_seq.sv
// Flash read sequencer: turns (addr, len, cs) requests into SPIM command words,
// one SOT..EOT frame per MAX_BURST chunk. UDMA_QSPI_CMD_SEQ_CFG_CACHE_EN skips repeated CFG words.
module udma_qspi_cmd_seq
  import udma_qspi_cmd_seq_pkg::*;
#(
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned MAX_BURST = 256,
  parameter logic        EOT_EVT   = 1'b1
) (
  input  logic             sys_clk_i,
  input  logic             rstn_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_addr_i,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic [1:0]       req_cs_i,
  input  logic [7:0]       cfg_clkdiv_i,
  input  logic [1:0]       cfg_mode_i,
  input  logic [7:0]       cfg_opcode_i,
  input  logic             cfg_addr4b_i,
  input  logic [4:0]       cfg_dummy_i,
  input  logic             cfg_qpi_i,
  output logic [31:0]      cmd_o,
  output logic             cmd_valid_o,
  input  logic             cmd_ready_i,
  input  logic             clr_i,
  output logic             busy_o,
  output logic             done_o
);

  cmd_seq_state_e   state_q, state_d;
  seq_req_t         req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             abort_q, abort_d;
  logic [31:0]      cmd_q, cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             req_ready_q, req_ready_d;

  logic             hs;
  logic             req_acc;
  logic             stop;
  logic             cfg_hit;
  logic [31:0]      chunk_cur;
  logic [31:0]      chunk_nxt;

  function automatic logic [31:0] chunk_of(input logic [LEN_W-1:0] rem);
    logic [31:0] r;
    r = 32'(rem);
    return (r > 32'(MAX_BURST)) ? 32'(MAX_BURST) : r;
  endfunction

  assign hs        = cmd_valid_q & cmd_ready_i;
  assign req_acc   = req_valid_i & req_ready_q;
  assign stop      = abort_q | clr_i;
  assign chunk_cur = chunk_of(rem_q);
  assign chunk_nxt = chunk_of(rem_d);

`ifdef UDMA_QSPI_CMD_SEQ_CFG_CACHE_EN
  // Last {clkdiv,mode} actually accepted by the SPIM
  logic       cache_vld_q;
  logic [9:0] cache_q;

  assign cfg_hit = cache_vld_q & (cache_q == {cfg_clkdiv_i, cfg_mode_i});

  always_ff @(posedge sys_clk_i) begin
    if (!rstn_i) begin
      cache_vld_q <= 1'b0;
      cache_q     <= '0;
    end else if (state_q == ST_CFG && hs) begin
      cache_vld_q <= 1'b1;
      cache_q     <= {req_q.clkdiv, req_q.mode};
    end
  end
`else
  assign cfg_hit = 1'b0;
`endif

  always_ff @(posedge sys_clk_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state plus request/address/length bookkeeping
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    abort_d = abort_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (req_acc) begin
          req_d.clkdiv = cfg_clkdiv_i;
          req_d.mode   = cfg_mode_i;
          req_d.opcode = cfg_opcode_i;
          req_d.addr4b = cfg_addr4b_i;
          req_d.dummy  = cfg_dummy_i;
          req_d.qpi    = cfg_qpi_i;
          req_d.cs     = req_cs_i;
          addr_d       = req_addr_i;
          rem_d        = req_len_i;
          if (req_len_i == '0) done_d  = 1'b1;
          else if (cfg_hit)    state_d = ST_SOT;
          else                 state_d = ST_CFG;
        end
      end
      ST_CFG: begin
        if (clr_i)   state_d = ST_IDLE;
        else if (hs) state_d = ST_SOT;
      end
      // Once SOT is taken, chip select must be released by an EOT even when aborting
      ST_SOT: begin
        abort_d = clr_i;
        if (hs)         state_d = clr_i ? ST_EOT : ST_CMD;
        else if (clr_i) state_d = ST_IDLE;
      end
      ST_CMD, ST_ADDR_HDR, ST_ADDR_DAT, ST_DUMMY, ST_RX: begin
        abort_d = stop;
        if (hs) begin
          if (stop) state_d = ST_EOT;
          else begin
            unique case (state_q)
              ST_CMD:      state_d = ST_ADDR_HDR;
              ST_ADDR_HDR: state_d = ST_ADDR_DAT;
              ST_ADDR_DAT: state_d = (req_q.dummy != 5'd0) ? ST_DUMMY : ST_RX;
              ST_DUMMY:    state_d = ST_RX;
              default:     state_d = ST_EOT;
            endcase
          end
        end
      end
      ST_EOT: begin
        abort_d = stop;
        if (hs) begin
          addr_d = addr_q + chunk_cur;
          rem_d  = rem_q - LEN_W'(chunk_cur);
          if (stop || rem_d == '0) begin
            state_d = ST_IDLE;
            done_d  = ~stop;
          end else begin
            state_d = ST_SOT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Word for the state being entered; unchanged inputs keep it stable while stalled
  always_comb begin
    cmd_d       = '0;
    cmd_valid_d = (state_d != ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    req_ready_d = (state_d == ST_IDLE);
    unique case (state_d)
      ST_CFG:      cmd_d = spim_cfg_word(req_d.clkdiv, req_d.mode);
      ST_SOT:      cmd_d = spim_sot_word(req_d.cs);
      ST_CMD:      cmd_d = spim_send_cmd_word(req_d.qpi, req_d.opcode);
      ST_ADDR_HDR: cmd_d = spim_send_addr_word(req_d.qpi, req_d.addr4b);
      ST_ADDR_DAT: cmd_d = req_d.addr4b ? addr_d : {8'h00, addr_d[23:0]};
      ST_DUMMY:    cmd_d = spim_dummy_word(req_d.dummy);
      ST_RX:       cmd_d = spim_rx_word(req_d.qpi, 16'(chunk_nxt - 32'd1));
      ST_EOT:      cmd_d = spim_eot_word(EOT_EVT);
      default:     cmd_d = '0;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (!rstn_i) begin
      req_q       <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      abort_q     <= 1'b0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      req_q       <= req_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      abort_q     <= abort_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign cmd_o       = cmd_q;
  assign cmd_valid_o = cmd_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign req_ready_o = req_ready_q;

endmodule

// File: tb/tb_udma_qspi_cmd_seq.sv
// Self-checking bench for udma_qspi_cmd_seq: randomized requests and backpressure
// checked against a frame-level model of the command stream.
module tb_udma_qspi_cmd_seq;

  localparam int unsigned MAX_BURST = 256;

  logic        sys_clk_i;
  logic        rstn_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [15:0] req_len_i;
  logic [1:0]  req_cs_i;
  logic [7:0]  cfg_clkdiv_i;
  logic [1:0]  cfg_mode_i;
  logic [7:0]  cfg_opcode_i;
  logic        cfg_addr4b_i;
  logic [4:0]  cfg_dummy_i;
  logic        cfg_qpi_i;
  logic [31:0] cmd_o;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic        clr_i;
  logic        busy_o;
  logic        done_o;

  udma_qspi_cmd_seq #(.LEN_W(16), .MAX_BURST(MAX_BURST), .EOT_EVT(1'b1)) dut (
    .sys_clk_i    (sys_clk_i),
    .rstn_i       (rstn_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_len_i    (req_len_i),
    .req_cs_i     (req_cs_i),
    .cfg_clkdiv_i (cfg_clkdiv_i),
    .cfg_mode_i   (cfg_mode_i),
    .cfg_opcode_i (cfg_opcode_i),
    .cfg_addr4b_i (cfg_addr4b_i),
    .cfg_dummy_i  (cfg_dummy_i),
    .cfg_qpi_i    (cfg_qpi_i),
    .cmd_o        (cmd_o),
    .cmd_valid_o  (cmd_valid_o),
    .cmd_ready_i  (cmd_ready_i),
    .clr_i        (clr_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial sys_clk_i = 1'b0;
  always #5 sys_clk_i = ~sys_clk_i;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned done_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  bit          bp_en = 1'b0;
  bit          manual = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_cmd = '0;
  logic        s_done, s_busy, s_valid;
`ifdef UDMA_QSPI_CMD_SEQ_CFG_CACHE_EN
  bit          cache_vld = 1'b0;
  logic [9:0]  cache_val = '0;
`endif

  // One clock: sample at negedge, then drive inputs 2 time units after posedge
  task automatic cycle();
    @(negedge sys_clk_i);
    if (prev_stall) begin
      n_vec++;
      if (cmd_valid_o !== 1'b1 || cmd_o !== prev_cmd) begin
        n_err++;
        $display("FAIL stall_hold: valid=%b cmd_o=%h, required valid=1 cmd_o=%h", cmd_valid_o, cmd_o, prev_cmd);
      end
    end
    prev_stall = rstn_i && !clr_i && cmd_valid_o && !cmd_ready_i;
    prev_cmd   = cmd_o;
    if (rstn_i && cmd_valid_o && cmd_ready_i) got_q.push_back(cmd_o);
    if (done_o === 1'b1) done_cnt++;
    s_done  = done_o;
    s_busy  = busy_o;
    s_valid = cmd_valid_o;
    @(posedge sys_clk_i);
    #2;
    if (!manual) cmd_ready_i = bp_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
  endtask

  task automatic set_cfg(input logic [7:0] clkdiv, input logic [1:0] mode, input logic [7:0] op,
                         input logic a4, input logic [4:0] dummy, input logic qpi);
    cfg_clkdiv_i = clkdiv; cfg_mode_i = mode; cfg_opcode_i = op;
    cfg_addr4b_i = a4; cfg_dummy_i = dummy; cfg_qpi_i = qpi;
  endtask

  // Expected word stream for one read: frames of at most MAX_BURST bytes
  task automatic model(input logic [31:0] addr, input int unsigned len, input logic [1:0] cs);
    int unsigned rem, n;
    logic [31:0] a;
    bit emit_cfg;
    emit_cfg = 1'b1;
`ifdef UDMA_QSPI_CMD_SEQ_CFG_CACHE_EN
    if (len != 0) begin
      emit_cfg = !(cache_vld && cache_val == {cfg_clkdiv_i, cfg_mode_i});
      cache_vld = 1'b1;
      cache_val = {cfg_clkdiv_i, cfg_mode_i};
    end
`endif
    rem = len;
    a   = addr;
    while (rem > 0) begin
      n = (rem > MAX_BURST) ? MAX_BURST : rem;
      if (emit_cfg) exp_q.push_back({4'h0, 18'h0, cfg_mode_i, cfg_clkdiv_i});
      emit_cfg = 1'b0;
      exp_q.push_back({4'h1, 26'h0, cs});
      exp_q.push_back({4'h2, cfg_qpi_i, 7'h0, 4'h7, 8'h0, cfg_opcode_i});
      exp_q.push_back({4'h3, cfg_qpi_i, 6'h0, (cfg_addr4b_i ? 5'd31 : 5'd23), 16'h0});
      exp_q.push_back(cfg_addr4b_i ? a : {8'h00, a[23:0]});
      if (cfg_dummy_i != 5'd0) exp_q.push_back({4'h4, 7'h0, cfg_dummy_i - 5'd1, 16'h0});
      exp_q.push_back({4'h7, cfg_qpi_i, 11'h0, 16'(n - 1)});
      exp_q.push_back({4'h9, 27'h0, 1'b1});
      a   = a + n;
      rem = rem - n;
    end
  endtask

  task automatic send_req(input logic [31:0] a, input logic [15:0] l, input logic [1:0] cs, output bit ok);
    req_addr_i = a; req_len_i = l; req_cs_i = cs; req_valid_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = req_ready_o;
      cycle();
    end
    req_valid_i = 1'b0;
  endtask

  task automatic compare_stream(input string name);
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s word_count: got %0d words, required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s word[%0d]: got %h, required %h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic run_txn(input logic [31:0] a, input int unsigned l, input logic [1:0] cs, input string name);
    bit ok;
    int unsigned d0;
    got_q.delete();
    exp_q.delete();
    model(a, l, cs);
    d0 = done_cnt;
    send_req(a, 16'(l), cs, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s accept: req_ready_o stayed %b, required 1", name, req_ready_o);
      return;
    end
    for (int i = 0; i < 4000 && done_cnt == d0; i++) cycle();
    n_vec++;
    if (done_cnt != d0 + 1) begin
      n_err++;
      $display("FAIL %s done: %0d pulses, required 1", name, done_cnt - d0);
    end
    compare_stream(name);
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    cycle(); cycle();
    n_vec++;
    if (req_ready_o !== 1'b0 || cmd_valid_o !== 1'b0 || cmd_o !== 32'h0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy=%b vld=%b cmd=%h busy=%b done=%b, required 0 0 0 0 0",
               req_ready_o, cmd_valid_o, cmd_o, busy_o, done_o);
    end
    rstn_i = 1'b1;
    cycle();
    n_vec++;
    if (req_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_idle_ready: req_ready_o=%b, required 1", req_ready_o);
    end
  endtask

  task automatic test_spec_vector();
    logic [31:0] lit [8];
    lit[0] = 32'h00000004; lit[1] = 32'h10000001; lit[2] = 32'h2007006B; lit[3] = 32'h30170000;
    lit[4] = 32'h00001000; lit[5] = 32'h40070000; lit[6] = 32'h7000000F; lit[7] = 32'h90000001;
    set_cfg(8'd4, 2'd0, 8'h6B, 1'b0, 5'd8, 1'b0);
    run_txn(32'h0000_1000, 16, 2'd1, "spec_vec");
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (i >= got_q.size() || got_q[i] !== lit[i]) begin
        n_err++;
        $display("FAIL spec_vec_lit[%0d]: got %h, required %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, lit[i]);
      end
    end
  endtask

  task automatic test_burst_wrap();
    logic [15:0] rx_exp [3];
    logic [31:0] ad_exp [3];
    logic [15:0] rx_seen [3];
    logic [31:0] ad_seen [3];
    int unsigned nr, na, ncfg;
    bit is_addr;
    rx_exp[0] = 16'd255; rx_exp[1] = 16'd255; rx_exp[2] = 16'd87;
    ad_exp[0] = 32'hFFFF_FF00; ad_exp[1] = 32'h0000_0000; ad_exp[2] = 32'h0000_0100;
    set_cfg(8'd2, 2'd3, 8'hEB, 1'b1, 5'd6, 1'b1);
    bp_en = 1'b1;
    run_txn(32'hFFFF_FF00, 600, 2'd2, "burst");
    nr = 0; na = 0; ncfg = 0; is_addr = 1'b0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (is_addr) begin
        if (na < 3) ad_seen[na] = got_q[i];
        na++;
        is_addr = 1'b0;
      end else if (got_q[i][31:28] == 4'h3) is_addr = 1'b1;
      else if (got_q[i][31:28] == 4'h7) begin
        if (nr < 3) rx_seen[nr] = got_q[i][15:0];
        nr++;
      end else if (got_q[i][31:28] == 4'h0) ncfg++;
    end
    n_vec++;
    if (nr != 3 || na != 3 || ncfg != 1) begin
      n_err++;
      $display("FAIL burst_frames: rx=%0d addr=%0d cfg=%0d, required 3 3 1", nr, na, ncfg);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (rx_seen[i] !== rx_exp[i] || ad_seen[i] !== ad_exp[i]) begin
          n_err++;
          $display("FAIL burst_frame[%0d]: rx %0d addr %h, required rx %0d addr %h",
                   i, rx_seen[i], ad_seen[i], rx_exp[i], ad_exp[i]);
        end
      end
    end
  endtask

  task automatic test_len0();
    bit ok;
    int unsigned d0;
    bp_en = 1'b0;
    got_q.delete();
    d0 = done_cnt;
    send_req(32'h1234_5678, 16'd0, 2'd0, ok);
    cycle();
    n_vec++;
    if (!ok || s_done !== 1'b1 || s_busy !== 1'b0 || s_valid !== 1'b0) begin
      n_err++;
      $display("FAIL len0_pulse: acc=%b done=%b busy=%b valid=%b, required 1 1 0 0", ok, s_done, s_busy, s_valid);
    end
    cycle();
    n_vec++;
    if (s_done !== 1'b0 || got_q.size() != 0 || done_cnt != d0 + 1) begin
      n_err++;
      $display("FAIL len0_after: done=%b words=%0d pulses=%0d, required 0 0 1", s_done, got_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    bp_en = 1'b1;
    set_cfg(8'd3, 2'd1, 8'h0B, 1'b0, 5'd0, 1'b0);
    run_txn(32'h0040_0000, 40, 2'd3, "b2b_first");
    run_txn(32'h0050_0010, 300, 2'd3, "b2b_second");
  endtask

  task automatic test_random();
    int unsigned len;
    logic [4:0] dm;
    bp_en = 1'b1;
    for (int t = 0; t < 16; t++) begin
      dm  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      set_cfg(8'($urandom_range(1, 2)), 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), dm, 1'($urandom));
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : $urandom_range(1, 700);
      run_txn($urandom, len, 2'($urandom), "rand");
    end
  endtask

  task automatic test_clr_rx();
    bit ok, seen;
    int unsigned d0;
    logic [31:0] tmp[$];
    manual = 1'b1;
    cmd_ready_i = 1'b1;
    set_cfg(8'd5, 2'd2, 8'h03, 1'b0, 5'd0, 1'b0);
    got_q.delete(); exp_q.delete();
    model(32'h0000_2000, 600, 2'd1);
    for (int i = 0; i < exp_q.size(); i++) begin
      tmp.push_back(exp_q[i]);
      if (exp_q[i][31:28] == 4'h7) break;
    end
    tmp.push_back(32'h9000_0001);
    exp_q = tmp;
    d0 = done_cnt;
    send_req(32'h0000_2000, 16'd600, 2'd1, ok);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!seen && cmd_valid_o && cmd_o[31:28] == 4'h7) begin
        cmd_ready_i = 1'b0; clr_i = 1'b1;
        cycle();
        clr_i = 1'b0;
        cycle(); cycle();
        cmd_ready_i = 1'b1;
        seen = 1'b1;
      end
      if (seen && !busy_o) break;
      cycle();
    end
    cycle(); cycle(); cycle();
    n_vec++;
    if (!ok || !seen || done_cnt != d0 || busy_o !== 1'b0 || cmd_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL clr_rx_end: acc=%b rx_seen=%b done_pulses=%0d busy=%b valid=%b, required 1 1 0 0 0",
               ok, seen, done_cnt - d0, busy_o, cmd_valid_o);
    end
    compare_stream("clr_rx");
    manual = 1'b0;
  endtask

  task automatic test_clr_cfg();
    bit ok;
    int unsigned d0;
    manual = 1'b1;
    cmd_ready_i = 1'b0;
    set_cfg(8'd7, 2'd0, 8'h6B, 1'b0, 5'd8, 1'b0);
    got_q.delete();
    d0 = done_cnt;
    send_req(32'h0000_3000, 16'd32, 2'd2, ok);
    clr_i = 1'b1;
    cycle();
    clr_i = 1'b0;
    cmd_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    n_vec++;
    if (!ok || got_q.size() != 0 || done_cnt != d0 || busy_o !== 1'b0 || cmd_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL clr_cfg: acc=%b words=%0d done_pulses=%0d busy=%b valid=%b, required 1 0 0 0 0",
               ok, got_q.size(), done_cnt - d0, busy_o, cmd_valid_o);
    end
    manual = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok, hit;
    manual = 1'b1;
    cmd_ready_i = 1'b1;
    set_cfg(8'd2, 2'd3, 8'hEB, 1'b1, 5'd6, 1'b1);
    got_q.delete();
    send_req(32'h0000_4000, 16'd32, 2'd0, ok);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (cmd_valid_o && cmd_o[31:28] == 4'h3) begin
        cycle();
        cmd_ready_i = 1'b0;
        rstn_i = 1'b0;
        cycle();
        hit = 1'b1;
      end else cycle();
    end
    n_vec++;
    if (!ok || !hit || cmd_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: acc=%b reached=%b valid=%b busy=%b, required 1 1 0 0", ok, hit, cmd_valid_o, busy_o);
    end
    rstn_i = 1'b1;
`ifdef UDMA_QSPI_CMD_SEQ_CFG_CACHE_EN
    cache_vld = 1'b0;
`endif
    manual = 1'b0;
    bp_en = 1'b1;
    cycle();
    run_txn(32'h0000_4000, 32, 2'd0, "after_reset");
    n_vec++;
    if (got_q.size() == 0 || got_q[0][31:28] !== 4'h0) begin
      n_err++;
      $display("FAIL after_reset_cfg_first: first opcode %h, required 0", (got_q.size() != 0) ? got_q[0][31:28] : 4'hx);
    end
  endtask

  initial begin
    rstn_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_len_i = '0; req_cs_i = '0;
    cmd_ready_i = 1'b1; clr_i = 1'b0;
    set_cfg(8'd1, 2'd0, 8'h03, 1'b0, 5'd0, 1'b0);
    test_reset();
    test_spec_vector();
    test_burst_wrap();
    test_len0();
    test_back_to_back();
    test_random();
    test_clr_rx();
    test_clr_cfg();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
